multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//   Moore controller that sequences the shared multicycle MIPS datapath (PC, memory, IR, regfile, ALU).
//   Decodes opcode, steps fetch/decode/execute/mem/writeback states and drives every datapath enable.
//   Adds a memory wait handshake with timeout, plus an illegal-opcode trap.
//   Sits between the top-level go/run control and the datapath.
// PARAMETERS
//   STATE_W      4   width of cstate encoding
//   TIMEOUT_CYC  16  max cycles spent waiting on mem_ready before trapping (>=1)
//   CNT_W        5   wait-counter width; must hold TIMEOUT_CYC
// PORTS
//   clk           in   1  rising-edge clock
//   rst_n         in   1  async active-low reset
//   go            in   1  run enable; sampled in IDLE and at each instruction end
//   op            in   6  IR[31:26] opcode
//   mem_ready     in   1  memory completes the access in this cycle
//   pc_write      out  1  unconditional PC load
//   pc_write_cond out  1  PC load if ALU zero (beq) / not-zero (bne)
//   branch_ne     out  1  selects not-zero condition (0 unless BNE_SUPPORT_EN)
//   i_or_d        out  1  0=PC addresses memory, 1=ALUOut addresses memory
//   mem_read      out  1  memory read strobe
//   mem_write     out  1  memory write strobe
//   ir_write      out  1  IR load
//   mem_to_reg    out  1  regfile write data: 0=ALUOut, 1=MDR
//   reg_dst       out  1  write reg: 0=rt, 1=rd
//   reg_write     out  1  regfile write enable
//   alu_src_a     out  1  0=PC, 1=A
//   alu_src_b     out  2  0=B, 1=const 4, 2=sign-ext imm, 3=imm<<2
//   alu_op        out  2  0=add, 1=sub, 2=funct field
//   pc_src        out  2  0=ALU result, 1=ALUOut, 2=jump target
//   busy          out  1  1 in every state except IDLE and TRAP
//   illegal       out  1  1 while in TRAP
//   cstate        out  4  current state, for debug
// BEHAVIOUR
//   - Reset (async, any state, including mid-access) -> IDLE; every output 0; wait counter 0.
//   - State encodings: IDLE0 FETCH1 DECODE2 MEMADR3 MEMRD4 MEMWB5 MEMWR6 EXEC7 ALUWB8 BRANCH9
//     ADDIEX10 ADDIWB11 JUMP12 BNE13 TRAP14. Encoding 15 -> TRAP next cycle.
//   - All outputs decode from registered cstate only. The only exception: strobes qualified by mem_ready (below).
//   - IDLE: go=1 -> FETCH; otherwise stay.
//   - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
//     ir_write and pc_write assert only in the cycle mem_ready=1, and FETCH -> DECODE on that cycle.
//   - DECODE: alu_src_a=0, alu_src_b=3, alu_op=0. Next state by op:
//       000000 -> EXEC; 100011/101011 -> MEMADR; 000100 -> BRANCH; 001000 -> ADDIEX;
//       000010 -> JUMP; 000101 -> BNE (macro) or TRAP; anything else -> TRAP.
//   - MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. Next: lw -> MEMRD, sw -> MEMWR.
//   - MEMRD: mem_read=1, i_or_d=1. Wait for mem_ready, then -> MEMWB.
//   - MEMWR: mem_write=1, i_or_d=1. Wait for mem_ready, then instruction end.
//   - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
//   - EXEC: alu_src_a=1, alu_src_b=0, alu_op=2 -> ALUWB.
//   - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0.
//   - BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_src=1.
//   - ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=0 -> ADDIWB.
//   - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
//   - JUMP: pc_write=1, pc_src=2.
//   - Instruction end (MEMWB, MEMWR+ready, ALUWB, BRANCH, ADDIWB, JUMP, BNE): go=1 -> FETCH, go=0 -> IDLE.
//     Dropping go mid-instruction never aborts the instruction.
//   - Wait counter: counts each FETCH/MEMRD/MEMWR cycle with mem_ready=0; clears on leaving the state.
//     On reaching TIMEOUT_CYC -> TRAP; no strobe completes and no pc/ir/reg write occurs.
//   - TRAP: all strobes 0, illegal=1, sticky; only rst_n exits.
//   - Latency with mem_ready tied 1: R/addi 4 cycles, lw 5, sw 4, beq/j 3.
// CONFIGURATION
//   BNE_SUPPORT_EN defined:
//     op 000101 -> BNE state: same outputs as BRANCH plus branch_ne=1.
//   Undefined:
//     op 000101 -> TRAP; BNE state unreachable; branch_ne tied 0.
// TESTING
//   1. rst_n=0 mid-MEMRD -> cstate=0 immediately; all outputs 0. Release with go=1 -> FETCH next edge.
//   2. go=1, mem_ready=1, op=100011 -> states 1,2,3,4,5 then 1; reg_write=1 only in state 5.
//   3. FETCH with mem_ready low 3 cycles -> ir_write/pc_write stay 0 for those cycles; pulse once on 4th cycle.
//   4. mem_ready held 0 in MEMWR -> TRAP after TIMEOUT_CYC (16) cycles; mem_write never completes;
//      illegal=1 until reset.
//   5. op=000101 -> with BNE_SUPPORT_EN: states 1,2,13, branch_ne=1; without the macro: TRAP.
//   6. op=000000 with go dropped in EXEC -> ALUWB completes with reg_write=1, then IDLE, busy=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the shared multicycle MIPS datapath, with mem_ready wait/timeout and illegal-op trap.
// Optional BNE decode is enabled by defining BNE_SUPPORT_EN; otherwise op 000101 traps and branch_ne stays 0.
module multicycle_control_fsm #(
  parameter int STATE_W     = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               busy,
  output logic               illegal,
  output logic [STATE_W-1:0] cstate
);

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
    ALUWB  = 4'd8,  BRANCH = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    JUMP   = 4'd12, BNE    = 4'd13, TRAP   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_SUPPORT_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;
  state_t           end_next;

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYC));
  // go is only honoured at instruction boundaries, so it can never abort a sequence
  assign end_next    = go ? FETCH : IDLE;
  assign cstate      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    pc_src        = 2'd0;
    busy          = 1'b1;
    illegal       = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (go) state_d = FETCH;
      end
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        // IR and PC update only on the cycle memory actually returns the word
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (timeout_hit) begin
          state_d = TRAP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DECODE: begin
        alu_src_b = 2'd3;
        case (op)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
`ifdef BNE_SUPPORT_EN
          OP_BNE:       state_d = BNE;
`endif
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)        state_d = MEMWB;
        else if (timeout_hit) state_d = TRAP;
        else                  cnt_d   = cnt_inc;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = end_next;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready)        state_d = end_next;
        else if (timeout_hit) state_d = TRAP;
        else                  cnt_d   = cnt_inc;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = end_next;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_src        = 2'd1;
        state_d       = end_next;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = end_next;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
        state_d  = end_next;
      end
`ifdef BNE_SUPPORT_EN
      BNE: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_src        = 2'd1;
        branch_ne     = 1'b1;
        state_d       = end_next;
      end
`endif
      TRAP: begin
        busy    = 1'b0;
        illegal = 1'b1;
      end
      // unused encodings fall into the trap on the next edge
      default: state_d = TRAP;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: per-instruction phase lists and a control-word table.
// Build with or without BNE_SUPPORT_EN to match the design.
module tb_multicycle_control_fsm;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4,
                 S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_ALUWB = 8, S_BRANCH = 9,
                 S_ADDIEX = 10, S_ADDIWB = 11, S_JUMP = 12, S_BNE = 13, S_TRAP = 14;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_BNE = 6'b000101, OP_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n, go, mem_ready;
  logic [5:0] op;
  logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, busy, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] cstate;
  logic [18:0] ctrl;

  int errors = 0;
  int checks = 0;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .go(go), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .busy(busy), .illegal(illegal), .cstate(cstate)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                 busy, illegal};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected control word for a state (and mem_ready, for the FETCH write pulse)
  function automatic logic [18:0] exp_ctrl(input int s, input logic r);
    logic pw, pwc, bne, iod, mr, mw, irw, m2r, rd, rw, asa, bsy, ill;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, bne, iod, mr, mw, irw, m2r, rd, rw, asa, bsy, ill} = '0;
    asb = 2'd0; aop = 2'd0; psrc = 2'd0;
    bsy = (s != S_IDLE) && (s != S_TRAP);
    case (s)
      S_FETCH:  begin mr = 1; asb = 2'd1; irw = r; pw = r; end
      S_DECODE: asb = 2'd3;
      S_MEMADR: begin asa = 1; asb = 2'd2; end
      S_MEMRD:  begin mr = 1; iod = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin mw = 1; iod = 1; end
      S_EXEC:   begin asa = 1; aop = 2'd2; end
      S_ALUWB:  begin rw = 1; rd = 1; end
      S_BRANCH: begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; end
      S_ADDIEX: begin asa = 1; asb = 2'd2; end
      S_ADDIWB: rw = 1;
      S_JUMP:   begin pw = 1; psrc = 2'd2; end
      S_BNE:    begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; bne = 1; end
      S_TRAP:   ill = 1;
      default:  ;
    endcase
    return {pw, pwc, bne, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, bsy, ill};
  endfunction

  task automatic step(input int es, input logic r, input logic g, input logic [5:0] o,
                      input string tag);
    @(negedge clk);
    mem_ready = r; go = g; op = o;
    #1;
    checks++;
    assert (cstate === 4'(es)) else begin
      errors++;
      $error("FAIL %s state: got %0d want %0d", tag, cstate, es);
    end
    checks++;
    assert (ctrl === exp_ctrl(es, r)) else begin
      errors++;
      $error("FAIL %s ctrl(st%0d): got %b want %b", tag, es, ctrl, exp_ctrl(es, r));
    end
  endtask

  // Asynchronous reset away from any edge, then release with go=1 so FETCH follows
  task automatic apply_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    assert (cstate === 4'd0) else begin
      errors++;
      $error("FAIL %s reset state: got %0d want 0", tag, cstate);
    end
    checks++;
    assert (ctrl === 19'd0) else begin
      errors++;
      $error("FAIL %s reset outputs: got %b want 0", tag, ctrl);
    end
    @(negedge clk);
    rst_n = 1'b1; go = 1'b1; mem_ready = 1'b0;
  endtask

  // Runs one legal instruction starting in FETCH; always leaves the FSM about to be in FETCH
  task automatic run_instr(input logic [5:0] o, input int sf, input int sm, input logic ge,
                           input string tag);
    for (int i = 0; i < sf; i++) step(S_FETCH, 1'b0, rb(), o, tag);
    step(S_FETCH, 1'b1, rb(), o, tag);
    step(S_DECODE, rb(), rb(), o, tag);
    case (o)
      OP_R:    begin step(S_EXEC, rb(), rb(), o, tag); step(S_ALUWB, rb(), ge, o, tag); end
      OP_LW:   begin
        step(S_MEMADR, rb(), rb(), o, tag);
        for (int i = 0; i < sm; i++) step(S_MEMRD, 1'b0, rb(), o, tag);
        step(S_MEMRD, 1'b1, rb(), o, tag);
        step(S_MEMWB, rb(), ge, o, tag);
      end
      OP_SW:   begin
        step(S_MEMADR, rb(), rb(), o, tag);
        for (int i = 0; i < sm; i++) step(S_MEMWR, 1'b0, rb(), o, tag);
        step(S_MEMWR, 1'b1, ge, o, tag);
      end
      OP_BEQ:  step(S_BRANCH, rb(), ge, o, tag);
      OP_ADDI: begin step(S_ADDIEX, rb(), rb(), o, tag); step(S_ADDIWB, rb(), ge, o, tag); end
      OP_J:    step(S_JUMP, rb(), ge, o, tag);
      default: ;
    endcase
    if (!ge) begin
      step(S_IDLE, rb(), 1'b0, 6'($urandom), {tag, "_idle"});
      step(S_IDLE, rb(), 1'b1, 6'($urandom), {tag, "_idle"});
    end
  endtask

  initial begin
    logic [5:0] ops [6];
    ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW;
    ops[3] = OP_BEQ; ops[4] = OP_ADDI; ops[5] = OP_J;

    rst_n = 1'b0; go = 1'b0; mem_ready = 1'b0; op = 6'd0;
    #3;
    apply_reset("por");

    run_instr(OP_LW, 0, 0, 1'b1, "lw_seq");
    run_instr(OP_R, 3, 0, 1'b1, "fetch_stall3");
    run_instr(OP_SW, 0, 15, 1'b1, "sw_stall15");
    run_instr(OP_R, 0, 0, 1'b0, "r_go_drop");
    run_instr(OP_BEQ, 0, 0, 1'b1, "beq_seq");
    run_instr(OP_J, 0, 0, 1'b1, "j_seq");
    run_instr(OP_ADDI, 2, 0, 1'b0, "addi_seq");

    for (int n = 0; n < 60; n++) begin
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 4), $urandom_range(0, 4),
                1'($urandom_range(0, 3) != 0), "rand");
    end

    step(S_FETCH, 1'b1, 1'b1, OP_LW, "rst_memrd");
    step(S_DECODE, 1'b0, 1'b1, OP_LW, "rst_memrd");
    step(S_MEMADR, 1'b0, 1'b1, OP_LW, "rst_memrd");
    step(S_MEMRD, 1'b0, 1'b1, OP_LW, "rst_memrd");
    apply_reset("rst_memrd");

    step(S_FETCH, 1'b1, 1'b1, OP_SW, "timeout");
    step(S_DECODE, 1'b0, 1'b1, OP_SW, "timeout");
    step(S_MEMADR, 1'b0, 1'b1, OP_SW, "timeout");
    for (int i = 0; i < 16; i++) step(S_MEMWR, 1'b0, 1'b1, OP_SW, "timeout_wait");
    for (int i = 0; i < 4; i++) step(S_TRAP, rb(), 1'b1, 6'($urandom), "trap_sticky");
    apply_reset("after_timeout");

    step(S_FETCH, 1'b1, 1'b1, OP_BNE, "bne");
    step(S_DECODE, rb(), 1'b1, OP_BNE, "bne");
`ifdef BNE_SUPPORT_EN
    step(S_BNE, rb(), 1'b0, OP_BNE, "bne");
    step(S_IDLE, rb(), 1'b0, OP_BNE, "bne_idle");
`else
    step(S_TRAP, rb(), 1'b1, OP_BNE, "bne_trap");
    step(S_TRAP, rb(), 1'b1, OP_BNE, "bne_trap");
`endif
    apply_reset("after_bne");

    step(S_FETCH, 1'b1, 1'b1, OP_BAD, "illegal_op");
    step(S_DECODE, rb(), 1'b1, OP_BAD, "illegal_op");
    step(S_TRAP, rb(), 1'b1, OP_LW, "illegal_trap");
    step(S_TRAP, rb(), 1'b1, OP_LW, "illegal_trap");
    apply_reset("after_illegal");
    run_instr(OP_LW, 0, 0, 1'b0, "post_reset_lw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
